// File: rtl/byte_striping_if.sv
// Stream-side bundle for byte_striping: word input, two lane outputs, counters and status.
// The master modport drives the word stream; the slave modport is the striper itself.
interface byte_striping_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              clear_cnt;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              phase;
  logic [CNT_W-1:0]  cnt_0;
  logic [CNT_W-1:0]  cnt_1;
  logic              idle;

  modport master (
    output data_in, valid_in, clear_cnt,
    input  lane_0, valid_0, lane_1, valid_1, phase, cnt_0, cnt_1, idle
  );

  modport slave (
    input  data_in, valid_in, clear_cnt,
    output lane_0, valid_0, lane_1, valid_1, phase, cnt_0, cnt_1, idle
  );
endinterface

// File: rtl/byte_striping.sv
// Two-lane word striper: alternate clk_2f slots go to lane_0 / lane_1, each lane held two cycles.
// Also keeps saturating per-lane word counters and a registered idle detector.
module byte_striping #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IDLE_CYC = 4
) (
  input logic            clk_2f,
  input logic            reset,
  byte_striping_if.slave bus
);

  localparam logic [3:0] IdleMax = 4'(IDLE_CYC);

  logic              phase_q, phase_d;
  logic [DATA_W-1:0] lane0_q, lane0_d, lane1_q, lane1_d;
  logic              valid0_q, valid0_d, valid1_q, valid1_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [3:0]        idle_cnt_q, idle_cnt_d;
  logic              idle_q, idle_d;
  logic [DATA_W-1:0] data_gated;

  always_comb begin
    phase_d    = ~phase_q;
    lane0_d    = lane0_q;
    lane1_d    = lane1_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    idle_cnt_d = idle_cnt_q;
    // Invalid slots zero the lane so stale data never rides a low valid.
    data_gated = bus.valid_in ? bus.data_in : '0;

    if (!phase_q) begin
      lane0_d  = data_gated;
      valid0_d = bus.valid_in;
    end else begin
      lane1_d  = data_gated;
      valid1_d = bus.valid_in;
    end

    if (bus.clear_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (bus.valid_in) begin
      if (!phase_q && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      if (phase_q && cnt1_q != '1)  cnt1_d = cnt1_q + CNT_W'(1);
    end

    if (bus.valid_in) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + 4'd1;
    end
    idle_d = (idle_cnt_d == IdleMax);
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      phase_q    <= 1'b0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.lane_0  = lane0_q;
  assign bus.valid_0 = valid0_q;
  assign bus.lane_1  = lane1_q;
  assign bus.valid_1 = valid1_q;
  assign bus.phase   = phase_q;
  assign bus.cnt_0   = cnt0_q;
  assign bus.cnt_1   = cnt1_q;
  assign bus.idle    = idle_q;

endmodule
